gf2m8_mul: RTL and testbench

//   GF(2^8) multiplier for the Reed-Solomon decoder datapath (syndrome, KES PEs, Chien/Forney).

---
 rtl/gf2m8_pkg.sv | 35 +++
 rtl/gf2m8_mul_xtime.sv | 14 +
 rtl/gf2m8_mul.sv | 78 +++++++
 tb/tb_gf2m8_mul.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/gf2m8_pkg.sv
// Shared GF(2^8) definitions for the Reed-Solomon datapath.
// Provides the field element type, the default field polynomial, and helpers
// for multiply-by-a and for building the a^8..a^14 reduction table.
package gf2m8_pkg;

  typedef logic [7:0] gf8_t;

  // Reduction table: entry m holds a^(8+m), m = 0..6.
  typedef logic [6:0][7:0] gf8_red_tbl_t;

  // Low 8 bits of x^8 + x^4 + x^3 + x^2 + 1 (0x11D).
  localparam gf8_t GF8_POLY_DEFAULT = 8'h1D;

  // Multiply a field element by a, folding x^8 back in through the polynomial.
  function automatic gf8_t gf8_xtime(input gf8_t a, input gf8_t poly);
    gf8_t shifted;
    shifted = {a[6:0], 1'b0};
    if (a[7]) begin
      return shifted ^ poly;
    end else begin
      return shifted;
    end
  endfunction

  // Build the a^8..a^14 constants for a given polynomial.
  function automatic gf8_red_tbl_t gf8_red_table(input gf8_t poly);
    gf8_red_tbl_t tbl;
    tbl[0] = poly;
    for (int m = 1; m < 7; m++) begin
      tbl[m] = gf8_xtime(tbl[m-1], poly);
    end
    return tbl;
  endfunction

endpackage

// File: rtl/gf2m8_mul_xtime.sv
// Multiply-by-a stage for GF(2^8).
// Pure combinational; chained in the multiplier to derive the reduction
// constants a^9..a^14 from the field polynomial.
module gf2m8_xtime
  import gf2m8_pkg::*;
(
  input  logic [7:0] a_i,
  input  logic [7:0] poly_i,
  output logic [7:0] z_o
);

  assign z_o = gf8_xtime(a_i, poly_i);

endmodule

// File: rtl/gf2m8_mul.sv
// GF(2^8) multiplier: z = x*y mod (x^8 + POLY).
// Carry-less 8x8 partial-product array followed by a single-level XOR
// reduction of p[14:8] through the constants a^8..a^14.
// Build option: define GF2M8_MUL_PIPE_EN to register z (latency 1, async
// active-low clear). Without it z is combinational and clk/rstn are unused.
module gf2m8_mul
  import gf2m8_pkg::*;
#(
  parameter logic [7:0] POLY = GF8_POLY_DEFAULT
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] x,
  input  logic [7:0] y,
  output logic [7:0] z
);

  // Reduction constants: red_s[m] = a^(8+m). a^8 is the polynomial itself;
  // each further power is one multiply-by-a. All inputs are constant, so the
  // chain collapses to wiring at elaboration.
  logic [7:0] red_s [7];
  logic [14:0] p_s;
  logic [7:0]  z_d;

  assign red_s[0] = POLY;

  for (genvar m = 1; m < 7; m++) begin : g_red
    gf2m8_xtime u_xtime (
      .a_i    (red_s[m-1]),
      .poly_i (POLY),
      .z_o    (red_s[m])
    );
  end

  // Carry-less product: p[k] is the XOR of every x[i]&y[j] with i+j == k.
  always_comb begin
    p_s = 15'h0000;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        p_s[i+j] = p_s[i+j] ^ (x[i] & y[j]);
      end
    end
  end

  // Fold the high coefficients back into 8 bits with one XOR level per output bit.
  always_comb begin
    z_d = p_s[7:0];
    for (int m = 0; m < 7; m++) begin
      if (p_s[8+m]) begin
        z_d = z_d ^ red_s[m];
      end else begin
        z_d = z_d;
      end
    end
  end

`ifdef GF2M8_MUL_PIPE_EN
  logic [7:0] z_q;

  // Output register: loads the product every edge, cleared at once by rstn.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      z_q <= 8'h00;
    end else begin
      z_q <= z_d;
    end
  end

  assign z = z_q;
`else
  // Clock and reset have no role in the combinational build.
  logic unused_s;
  assign unused_s = clk ^ rstn;

  assign z = z_d;
`endif

endmodule

// File: tb/tb_gf2m8_mul.sv
// Self-checking bench for gf2m8_mul.
// Directed vectors, exhaustive sweep against a shift-and-add model, antilog
// walk, POLY=8'h1B instance, and register/reset behaviour when
// GF2M8_MUL_PIPE_EN is defined.
module tb_gf2m8_mul;

  logic       clk;
  logic       rstn;
  logic [7:0] x;
  logic [7:0] y;
  logic [7:0] z;
  logic [7:0] z_aes;

  int n_vec;
  int n_err;

  gf2m8_mul #(.POLY(8'h1D)) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .x    (x),
    .y    (y),
    .z    (z)
  );

  gf2m8_mul #(.POLY(8'h1B)) u_dut_aes (
    .clk  (clk),
    .rstn (rstn),
    .x    (x),
    .y    (y),
    .z    (z_aes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shift-and-add reference: accumulate x*a^i for each set bit of y.
  function automatic logic [7:0] gf_ref(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] poly);
    logic [7:0] r;
    logic [7:0] aa;
    r  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ poly) : {aa[6:0], 1'b0};
    end
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one operand pair and wait until the product is visible on z.
  task automatic apply(input logic [7:0] a, input logic [7:0] b);
    x = a;
    y = b;
`ifdef GF2M8_MUL_PIPE_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  logic [7:0] e;
  logic [7:0] exp_e;
  bit         seen [256];
  int         distinct;

  initial begin
    n_vec = 0;
    n_err = 0;
    rstn  = 1'b0;
    x     = 8'h00;
    y     = 8'h00;
    repeat (2) @(posedge clk);
`ifdef GF2M8_MUL_PIPE_EN
    #1;
    check_eq("reset_z", {24'h0, z}, 32'h00);
    check_eq("reset_z_aes", {24'h0, z_aes}, 32'h00);
`endif
    @(negedge clk);
    rstn = 1'b1;

    // Directed vectors with hand-computed products.
    apply(8'h02, 8'h80); check_eq("a8", {24'h0, z}, 32'h1D);
    apply(8'h80, 8'h80); check_eq("a14", {24'h0, z}, 32'h13);
    apply(8'h02, 8'h8E); check_eq("inv_pair", {24'h0, z}, 32'h01);
    apply(8'h8E, 8'h02); check_eq("inv_pair_sw", {24'h0, z}, 32'h01);
    apply(8'h00, 8'hFF); check_eq("zero_x", {24'h0, z}, 32'h00);
    apply(8'hFF, 8'h00); check_eq("zero_y", {24'h0, z}, 32'h00);
    apply(8'h01, 8'hA7); check_eq("ident_x", {24'h0, z}, 32'hA7);
    apply(8'hA7, 8'h01); check_eq("ident_y", {24'h0, z}, 32'hA7);
    apply(8'h53, 8'hCA); check_eq("aes_inv", {24'h0, z_aes}, 32'h01);
    apply(8'h57, 8'h83); check_eq("aes_mul", {24'h0, z_aes}, 32'hC1);

    // Exhaustive sweep for both polynomials.
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 256; j++) begin
        apply(i[7:0], j[7:0]);
        check_eq("sweep_1d", {24'h0, z}, {24'h0, gf_ref(i[7:0], j[7:0], 8'h1D)});
        check_eq("sweep_1b", {24'h0, z_aes}, {24'h0, gf_ref(i[7:0], j[7:0], 8'h1B)});
      end
    end

    // Commutativity on a spread of asymmetric pairs, swapped order.
    for (int k = 0; k < 16; k++) begin
      logic [7:0] a;
      logic [7:0] b;
      a = 8'(k * 37 + 11);
      b = 8'(k * 91 + 200);
      apply(b, a);
      check_eq("commute", {24'h0, z}, {24'h0, gf_ref(a, b, 8'h1D)});
    end

    // Antilog walk: feed z back as x, multiplying by a each step.
    for (int k = 0; k < 256; k++) seen[k] = 1'b0;
    distinct = 0;
    e        = 8'h01;
    exp_e    = 8'h01;
    for (int s = 0; s < 255; s++) begin
      apply(e, 8'h02);
      exp_e = gf_ref(exp_e, 8'h02, 8'h1D);
      check_eq("alog_step", {24'h0, z}, {24'h0, exp_e});
      if (!seen[z]) begin
        seen[z] = 1'b1;
        distinct++;
      end
      e = z;
    end
    check_eq("alog_return", {24'h0, e}, 32'h01);
    check_eq("alog_distinct", distinct, 255);

`ifdef GF2M8_MUL_PIPE_EN
    // Latency: value appears only after the edge.
    @(negedge clk);
    x = 8'h80;
    y = 8'h80;
    #1;
    check_eq("pipe_hold", {24'h0, z}, {24'h0, exp_e});
    @(posedge clk);
    #1;
    check_eq("pipe_lat1", {24'h0, z}, 32'h13);
    // Asynchronous clear in mid-stream, away from any edge.
    #2;
    rstn = 1'b0;
    #1;
    check_eq("async_clr", {24'h0, z}, 32'h00);
    check_eq("async_clr_aes", {24'h0, z_aes}, 32'h00);
    @(posedge clk);
    #1;
    check_eq("clr_hold", {24'h0, z}, 32'h00);
    @(negedge clk);
    rstn = 1'b1;
    x = 8'h02;
    y = 8'h80;
    #1;
    check_eq("pre_edge", {24'h0, z}, 32'h00);
    @(posedge clk);
    #1;
    check_eq("first_edge", {24'h0, z}, 32'h1D);
`else
    // Combinational: output follows inputs without any edge.
    @(posedge clk);
    #2;
    x = 8'h80;
    y = 8'h80;
    #1;
    check_eq("comb_no_clk", {24'h0, z}, 32'h13);
    rstn = 1'b0;
    #1;
    check_eq("comb_rst_ignored", {24'h0, z}, 32'h13);
    rstn = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
